// File: rtl/zsy_oled_spi_stream_if.sv
// Write-side bus of zsy_oled_spi_stream: push handshake plus FIFO occupancy.
// Defining ZSY_SPI_FILL_EN adds the per-entry repeat count wr_rep.
interface zsy_oled_spi_stream_if #(
  parameter int unsigned FIFO_AW = 4
);
  logic             wr_en;
  logic             wr_dc;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic [FIFO_AW:0] fifo_level;
`ifdef ZSY_SPI_FILL_EN
  logic [10:0]      wr_rep;

  modport master (output wr_en, wr_dc, wr_data, wr_rep, input wr_ready, fifo_level);
  modport slave  (input wr_en, wr_dc, wr_data, wr_rep, output wr_ready, fifo_level);
`else
  modport master (output wr_en, wr_dc, wr_data, input wr_ready, fifo_level);
  modport slave  (input wr_en, wr_dc, wr_data, output wr_ready, fifo_level);
`endif
endinterface

// File: rtl/zsy_oled_spi_stream.sv
// Write-only 4-wire SPI master for SSD1306-class panels fed by a {dc, data} byte FIFO.
// ZSY_SPI_FILL_EN: each entry carries wr_rep and is sent wr_rep+1 times in one frame.
module zsy_oled_spi_stream #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned RST_CYCLES = 500,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  zsy_oled_spi_stream_if.slave        wr,
  output logic                        busy,
  output logic                        init_done,
  output logic                        ovf,
  output logic                        cs_n,
  output logic                        sclk,
  output logic                        dc,
  output logic                        sdin,
  output logic                        oled_rst
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned HcW   = $clog2(CLK_DIV);
  localparam int unsigned RcW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned GcW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {
    StRstHold,
    StIdle,
    StLoad,
    StBitLo,
    StBitHi,
    StEnd,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [HcW-1:0]     hcnt_q, hcnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic [RcW-1:0]     rcnt_q, rcnt_d;
  logic [GcW-1:0]     gcnt_q, gcnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] rd_idx;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               dc_q, dc_d;
  logic               sdin_q, sdin_d;
  logic               oled_rst_q, oled_rst_d;
  logic               init_done_q, init_done_d;
  logic               ovf_q, ovf_d;

  logic [7:0]         mem_data [Depth];
  logic               mem_dc   [Depth];

  logic               push;
  logic               half_done;
  logic               load;
  logic               held_pop;
  logic [1:0]         pop_cnt;

`ifdef ZSY_SPI_FILL_EN
  logic [10:0]        mem_rep [Depth];
  logic [10:0]        rep_q, rep_d;
  logic               held_q, held_d;
  logic [7:0]         cur_q, cur_d;
`endif

  assign wr.wr_ready   = (level_q != (FIFO_AW + 1)'(Depth));
  assign wr.fifo_level = level_q;
  assign push          = wr.wr_en && wr.wr_ready;
  assign half_done     = (hcnt_q == HcW'(CLK_DIV - 1));

  assign busy      = !(((state_q == StIdle) || (state_q == StRstHold)) && (level_q == '0));
  assign init_done = init_done_q;
  assign ovf       = ovf_q;
  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign dc        = dc_q;
  assign sdin      = sdin_q;
  assign oled_rst  = oled_rst_q;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = half_done ? '0 : hcnt_q + HcW'(1);
    bit_d       = bit_q;
    sh_d        = sh_q;
    rcnt_d      = rcnt_q;
    gcnt_d      = gcnt_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    dc_d        = dc_q;
    sdin_d      = sdin_q;
    oled_rst_d  = oled_rst_q;
    init_done_d = init_done_q;
    ovf_d       = ovf_q | (wr.wr_en & ~wr.wr_ready);
    load        = 1'b0;
    held_pop    = 1'b0;
    pop_cnt     = 2'd0;
`ifdef ZSY_SPI_FILL_EN
    rep_d       = rep_q;
    held_d      = held_q;
    cur_d       = cur_q;
`endif

    case (state_q)
      StRstHold: begin
        hcnt_d = '0;
        if (rcnt_q == RcW'(RST_CYCLES - 1)) begin
          oled_rst_d  = 1'b1;
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          rcnt_d = rcnt_q + RcW'(1);
        end
      end
      StIdle: begin
        hcnt_d = '0;
        if (level_q != '0) state_d = StLoad;
      end
      StLoad: begin
        // First cycle of a frame opens cs_n; back-to-back loads arrive with cs_n already low.
        if (cs_n_q) begin
          load   = 1'b1;
          hcnt_d = '0;
        end else if (half_done) begin
          sclk_d  = 1'b1;
          state_d = StBitHi;
        end
      end
      StBitLo: begin
        if (half_done) begin
          sclk_d  = 1'b1;
          state_d = StBitHi;
        end
      end
      StBitHi: begin
        if (half_done) begin
          sclk_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            sdin_d  = sh_q[6];
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = StBitLo;
          end else begin
`ifdef ZSY_SPI_FILL_EN
            held_pop = held_q && (rep_q == '0);
            if (rep_q != '0) begin
              rep_d   = rep_q - 11'd1;
              sh_d    = cur_q;
              sdin_d  = cur_q[7];
              bit_d   = 3'd7;
              state_d = StLoad;
            end else
`endif
            if (level_q > (FIFO_AW + 1)'(held_pop)) begin
              load    = 1'b1;
              state_d = StLoad;
            end else begin
              state_d = StEnd;
            end
          end
        end
      end
      StEnd: begin
        if (half_done) begin
          cs_n_d  = 1'b1;
          gcnt_d  = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (half_done) begin
          if (gcnt_q == GcW'(CS_GAP - 1)) state_d = StIdle;
          else gcnt_d = gcnt_q + GcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A finished repeated entry is retired on the same edge that may load its successor.
    rd_idx = rd_ptr_q + FIFO_AW'(held_pop);
`ifdef ZSY_SPI_FILL_EN
    if (held_pop) held_d = 1'b0;
`endif
    if (load) begin
      cs_n_d = 1'b0;
      dc_d   = mem_dc[rd_idx];
      sh_d   = mem_data[rd_idx];
      sdin_d = mem_data[rd_idx][7];
      bit_d  = 3'd7;
`ifdef ZSY_SPI_FILL_EN
      cur_d  = mem_data[rd_idx];
      rep_d  = mem_rep[rd_idx];
      held_d = (mem_rep[rd_idx] != '0);
`endif
    end

`ifdef ZSY_SPI_FILL_EN
    pop_cnt = {1'b0, held_pop} + {1'b0, load && (mem_rep[rd_idx] == '0)};
`else
    pop_cnt = {1'b0, load};
`endif

    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop_cnt);
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    level_d  = level_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRstHold;
      hcnt_q      <= '0;
      bit_q       <= 3'd7;
      sh_q        <= '0;
      rcnt_q      <= '0;
      gcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      dc_q        <= 1'b0;
      sdin_q      <= 1'b0;
      oled_rst_q  <= 1'b0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ZSY_SPI_FILL_EN
      rep_q       <= '0;
      held_q      <= 1'b0;
      cur_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rcnt_q      <= rcnt_d;
      gcnt_q      <= gcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      dc_q        <= dc_d;
      sdin_q      <= sdin_d;
      oled_rst_q  <= oled_rst_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
`ifdef ZSY_SPI_FILL_EN
      rep_q       <= rep_d;
      held_q      <= held_d;
      cur_q       <= cur_d;
`endif
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= wr.wr_data;
      mem_dc[wr_ptr_q]   <= wr.wr_dc;
`ifdef ZSY_SPI_FILL_EN
      mem_rep[wr_ptr_q]  <= wr.wr_rep;
`endif
    end
  end

endmodule
